// File: rtl/mult_arbiter.sv
// mult_arbiter: one shared unsigned multiplier serving NUM_REQ requesters.
// Arbitration is round-robin. The result goes into a single registered slot
// that is drained through a valid/ready handshake.
//
// Handshake semantics, identical on both sides: a transfer happens at a
// rising edge exactly when valid and ready are both high. The source holds
// valid and its payload stable until that edge. Ready may depend
// combinationally on valid (req_ready depends on req_valid and rsp_ready).

// Combinational WIDTH x WIDTH -> 2*WIDTH unsigned multiplier.
module multiply #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] p
);
    // Zero-extend both operands so that the full product is kept.
    assign p = (2*WIDTH)'(a) * (2*WIDTH)'(b);
endmodule

module mult_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [2*WIDTH-1:0]         rsp_c,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [15:0]                ops_done
);
    localparam int ID_W = $clog2(NUM_REQ);

    // Result-slot FSM. The state is visible in waves and to bound checkers
    // as the signal "state".
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] winner;
    logic [ID_W-1:0] ptr_after_win;
    logic            any_valid;
    logic            can_issue;
    logic            transfer;
    logic [WIDTH-1:0]   sel_a;
    logic [WIDTH-1:0]   sel_b;
    logic [2*WIDTH-1:0] product;

    // The slot can accept a new result when it is empty or is being drained
    // in this same cycle.
    assign can_issue = (state == EMPTY) | rsp_ready;
    assign transfer  = can_issue & any_valid;

    // Round-robin search: pick the first valid requester at or after rr_ptr.
    always_comb begin : arb_search
        int idx;
        idx       = 0;
        winner    = '0;
        any_valid = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!any_valid && req_valid[idx]) begin
                any_valid = 1'b1;
                winner    = ID_W'(idx);
            end
        end
    end

    assign ptr_after_win = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;

    // Operand mux feeds the single multiplier instance.
    assign sel_a = req_a[winner*WIDTH +: WIDTH];
    assign sel_b = req_b[winner*WIDTH +: WIDTH];

    multiply #(.WIDTH(WIDTH)) u_multiply (
        .a (sel_a),
        .b (sel_b),
        .p (product)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: fill on a grant, empty on a drain with no new grant.
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: if (any_valid) state_nxt = FULL;
            FULL:  if (rsp_ready) state_nxt = any_valid ? FULL : EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    // FSM outputs: one-hot grant and the slot-occupied flag.
    always_comb begin
        req_ready = '0;
        if (transfer) begin
            req_ready[winner] = 1'b1;
        end
        rsp_valid = (state == FULL);
    end

    // Result slot and priority pointer. Both change only on a request transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_c  <= '0;
            rsp_id <= '0;
            rr_ptr <= '0;
        end else if (transfer) begin
            rsp_c  <= product;
            rsp_id <= winner;
            rr_ptr <= ptr_after_win;
        end
    end

    // Count results accepted by the consumer; wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ops_done <= '0;
        end else if (rsp_valid && rsp_ready) begin
            ops_done <= ops_done + 16'd1;
        end
    end

endmodule
